// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, status-flag bit positions and the
// result-stage entry layout.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOT1 = 3'b110;
  localparam logic [2:0] OP_NOT2 = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_D = 3;

  localparam int ALU_RES_W = 32;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [ALU_RES_W-1:0] result;
    logic [3:0]           flags;
  } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Derives {D, C, N, Z} for one ALU result and forces the result to zero on a
// divide-by-zero.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int RES_W = 32
) (
  input  logic [2:0]       opcode,
  input  logic [RES_W-1:0] result,
  input  logic             div0,
  output logic [RES_W-1:0] forced_result,
  output logic [3:0]       flags
);

  always_comb begin
    forced_result = result;
    flags         = '0;
    flags[FLAG_D] = div0 && (opcode == OP_DIV);
    if (flags[FLAG_D]) forced_result = '0;
    flags[FLAG_Z] = (forced_result == '0);
    flags[FLAG_N] = forced_result[RES_W-1];
    // Bit 16 is the carry (add) or borrow (sub) out of the 16-bit datapath.
    flags[FLAG_C] = ((opcode == OP_ADD) || (opcode == OP_SUB)) && forced_result[16];
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: flags computed at push, entries buffered in a
// small FIFO, saturating divide-by-zero counter for debug readout.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RES_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_opcode,
  input  logic [RES_W-1:0]             in_result,
  input  logic                         in_div0,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RES_W-1:0]             out_result,
  output logic [2:0]                   out_opcode,
  output logic [3:0]                   out_flags,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [7:0]                   div0_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [2:0]       opcode;
    logic [RES_W-1:0] result;
    logic [3:0]       flags;
  } slot_t;

  slot_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [RES_W-1:0] gen_result;
  logic [3:0]       gen_flags;

  alu_flag_gen #(.RES_W(RES_W)) u_flag_gen (
    .opcode        (in_opcode),
    .result        (in_result),
    .div0          (in_div0),
    .forced_result (gen_result),
    .flags         (gen_flags)
  );

  // Handshake: a beat transfers on an edge where valid && ready. in_ready and
  // out_valid depend only on registered count, so neither side has a
  // combinational path to the other; a full FIFO refuses pushes even when
  // the head pops in the same cycle.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result = mem[rd_ptr].result;
  assign out_opcode = mem[rd_ptr].opcode;
  assign out_flags  = mem[rd_ptr].flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      div0_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{opcode: in_opcode, result: gen_result, flags: gen_flags};
        wr_ptr      <= wr_ptr + PTR_W'(1);
        if (gen_flags[FLAG_D] && (div0_cnt != 8'hFF)) div0_cnt <= div0_cnt + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: vector table, directed FIFO corner sequences and
// random traffic checked against a queue-based reference model.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int RES_W = 32;
  localparam int W     = 3 + RES_W + 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_opcode;
  logic [RES_W-1:0] in_result;
  logic             in_div0;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic [2:0]       out_opcode;
  logic [3:0]       out_flags;
  logic [2:0]       count;
  logic [7:0]       div0_cnt;

  alu_result_stage #(.DEPTH(DEPTH), .RES_W(RES_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_result  (in_result),
    .in_div0    (in_div0),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_opcode (out_opcode),
    .out_flags  (out_flags),
    .count      (count),
    .div0_cnt   (div0_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_div0;
  int           n_cmp;
  int           n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entry {opcode, stored result, D, C, N, Z} straight from the flag rules.
  function automatic logic [W-1:0] model_entry(input logic [2:0] op, input logic [RES_W-1:0] res,
                                               input logic d0);
    logic             d;
    logic [RES_W-1:0] r;
    logic             c;
    d = d0 && (op == 3'd3);
    r = d ? '0 : res;
    c = (op == 3'd0 || op == 3'd1) ? r[16] : 1'b0;
    return {op, r, d, c, r[RES_W-1], (r == 0)};
  endfunction

  task automatic check_outputs();
    logic [W-1:0] h;
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
    chk("div0_cnt", 64'(div0_cnt), 64'(exp_div0));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("out_opcode", 64'(out_opcode), 64'(h[W-1 -: 3]));
      chk("out_result", 64'(out_result), 64'(h[RES_W+3:4]));
      chk("out_flags", 64'(out_flags), 64'(h[3:0]));
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [2:0] op, input logic [RES_W-1:0] res,
                      input logic d0, input logic rdy);
    logic         acc;
    logic         pp;
    logic [W-1:0] e;
    in_valid  = v;
    in_opcode = op;
    in_result = res;
    in_div0   = d0;
    out_ready = rdy;
    acc = v && (exp_q.size() != DEPTH);
    pp  = (exp_q.size() != 0) && rdy;
    e   = model_entry(op, res, d0);
    @(posedge clk);
    #1;
    if (pp) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(e);
      if (e[3] && exp_div0 < 255) exp_div0++;
    end
    check_outputs();
  endtask

  task automatic do_reset(input logic v);
    rst       = 1'b1;
    in_valid  = v;
    in_opcode = 3'd3;
    in_result = 32'h1234_5678;
    in_div0   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_div0 = 0;
    check_outputs();
    chk("rst_out_result", 64'(out_result), 64'h0);
    chk("rst_out_opcode", 64'(out_opcode), 64'h0);
    chk("rst_out_flags", 64'(out_flags), 64'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic             valid;
    logic [2:0]       op;
    logic [RES_W-1:0] res;
    logic             d0;
    logic             exp_valid;
    logic [RES_W-1:0] exp_result;
    logic [3:0]       exp_flags;   // {D, C, N, Z}
    logic [2:0]       exp_count;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [RES_W-1:0] held;
    n_cmp    = 0;
    n_fail   = 0;
    exp_div0 = 0;
    rst      = 1'b1;
    in_valid = 1'b0; in_opcode = '0; in_result = '0; in_div0 = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset(1'b0);

    // out_ready stays 1: each row's entry is the head in the following cycle.
    vecs[0] = '{1'b1, OP_ADD,  32'h0001_0000, 1'b0, 1'b1, 32'h0001_0000, 4'b0100, 3'd1};
    vecs[1] = '{1'b1, OP_SUB,  32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 4'b0001, 3'd1};
    vecs[2] = '{1'b1, OP_SUB,  32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0110, 3'd1};
    vecs[3] = '{1'b1, OP_MUL,  32'h0001_0000, 1'b0, 1'b1, 32'h0001_0000, 4'b0000, 3'd1};
    vecs[4] = '{1'b1, OP_DIV,  32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0000, 4'b1001, 3'd1};
    vecs[5] = '{1'b1, OP_DIV,  32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 4'b0010, 3'd1};
    vecs[6] = '{1'b1, OP_AND,  32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 4'b0001, 3'd1};
    vecs[7] = '{1'b1, OP_NOT2, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0000, 3'd1};
    vecs[8] = '{1'b1, OP_OR,   32'h0000_0005, 1'b1, 1'b1, 32'h0000_0005, 4'b0000, 3'd1};
    vecs[9] = '{1'b0, OP_OR,   32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b0000, 3'd0};
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].valid, vecs[i].op, vecs[i].res, vecs[i].d0, 1'b1);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_result", i), 64'(out_result), 64'(vecs[i].exp_result));
        chk($sformatf("vec%0d_flags", i), 64'(out_flags), 64'(vecs[i].exp_flags));
      end
    end
    chk("table_div0_cnt", 64'(div0_cnt), 64'd1);

    // Fill to full with consumer stalled; a 5th push is refused.
    step(1'b1, OP_OR, 32'h11, 1'b0, 1'b0);
    step(1'b1, OP_OR, 32'h22, 1'b0, 1'b0);
    step(1'b1, OP_OR, 32'h33, 1'b0, 1'b0);
    step(1'b1, OP_OR, 32'h44, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    held = out_result;
    step(1'b1, OP_OR, 32'h55, 1'b0, 1'b0);
    step(1'b0, OP_OR, 32'h66, 1'b0, 1'b0);
    chk("stall_hold", 64'(out_result), 64'(held));
    chk("stall_head", 64'(out_result), 64'h11);
    // Full with a pop: the push is still refused.
    step(1'b1, OP_OR, 32'h77, 1'b0, 1'b1);
    chk("full_pop_count", 64'(count), 64'd3);
    chk("full_pop_head", 64'(out_result), 64'h22);
    repeat (3) step(1'b0, OP_OR, 32'h0, 1'b0, 1'b1);
    chk("drained", 64'(out_valid), 64'd0);

    // Steady count of 2 across pointer wrap.
    step(1'b1, OP_ADD, 32'h100, 1'b0, 1'b0);
    step(1'b1, OP_ADD, 32'h101, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, OP_ADD, 32'h200 + 32'(i), 1'b0, 1'b1);
    chk("steady_count", 64'(count), 64'd2);
    chk("steady_head", 64'(out_result), 64'h208);
    repeat (2) step(1'b0, OP_ADD, 32'h0, 1'b0, 1'b1);

    // Divide-by-zero counter saturation.
    for (int i = 0; i < 300; i++) step(1'b1, OP_DIV, $urandom, 1'b1, 1'b1);
    chk("div0_sat", 64'(div0_cnt), 64'd255);
    step(1'b0, OP_DIV, 32'h0, 1'b0, 1'b1);

    // Reset with three entries held and a beat in flight.
    repeat (3) step(1'b1, OP_SUB, $urandom, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    do_reset(1'b1);
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_div0", 64'(div0_cnt), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 7,
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
